// File: rtl/usb_pulpino_pkg.sv
// Shared defaults, width helper and GPIO field positions for the USB/PULPino mailbox.
package usb_pulpino_pkg;

    localparam int unsigned DefDataWidth = 8;
    localparam int unsigned DefDepth     = 8;

    // Occupancy counter must hold 0..depth inclusive, hence one extra bit.
    function automatic int unsigned CNT_W(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    // Bit positions of the status/flag fields in the PULPino GPIO status word.
    localparam int unsigned GpioU2pCountLsb = 0;
    localparam int unsigned GpioP2uCountLsb = 8;
    localparam int unsigned GpioU2pEmpty    = 16;
    localparam int unsigned GpioU2pFull     = 17;
    localparam int unsigned GpioP2uEmpty    = 18;
    localparam int unsigned GpioP2uFull     = 19;
    localparam int unsigned GpioU2pOvf      = 20;
    localparam int unsigned GpioU2pUnf      = 21;
    localparam int unsigned GpioP2uOvf      = 22;
    localparam int unsigned GpioP2uUnf      = 23;

endpackage

// File: rtl/usb_pulpino_mailbox_toggle_fifo.sv
// One mailbox direction: toggle-driven push/pop FIFO with registered head word
// and sticky overflow/underflow flags.
module toggle_fifo
    import usb_pulpino_pkg::*;
#(
    parameter int unsigned DataWidth = DefDataWidth,
    parameter int unsigned Depth     = DefDepth,
    parameter int unsigned CntW      = CNT_W(Depth)
) (
    input  logic                 clk,
    input  logic                 reset_i,
    input  logic                 wr_toggle,
    input  logic [DataWidth-1:0] wdata,
    input  logic                 rd_toggle,
    input  logic                 clr_err,
    output logic [DataWidth-1:0] rdata,
    output logic [CntW-1:0]      count,
    output logic                 empty,
    output logic                 full,
    output logic                 ovf,
    output logic                 unf
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic [DataWidth-1:0] mem_q [Depth];
    logic                 wr_shadow_q, rd_shadow_q;
    logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]      count_q, count_d;
    logic [DataWidth-1:0] rdata_q, rdata_d;
    logic                 ovf_q, ovf_d, unf_q, unf_d;
    logic                 wr_ev, rd_ev, is_empty, is_full, push_ok, pop_ok;

    // Event decode, pointer/count update and next head word.
    always_comb begin
        wr_ev    = wr_toggle ^ wr_shadow_q;
        rd_ev    = rd_toggle ^ rd_shadow_q;
        is_empty = (count_q == '0);
        is_full  = (count_q == CntW'(Depth));
        // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
        push_ok  = wr_ev & (~is_full | rd_ev);
        pop_ok   = rd_ev & ~is_empty;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
        if (push_ok && !pop_ok) count_d = count_q + CntW'(1);
        if (pop_ok && !push_ok) count_d = count_q - CntW'(1);

        // Bypass the word being written when it becomes the new head.
        if (count_d == '0) begin
            rdata_d = '0;
        end else if (push_ok && (wr_ptr_q == rd_ptr_d)) begin
            rdata_d = wdata;
        end else begin
            rdata_d = mem_q[rd_ptr_d];
        end

        ovf_d = clr_err ? 1'b0 : (ovf_q | (wr_ev & is_full & ~rd_ev));
        unf_d = clr_err ? 1'b0 : (unf_q | (rd_ev & is_empty));
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            wr_shadow_q <= 1'b0;
            rd_shadow_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rdata_q     <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            wr_shadow_q <= wr_toggle;
            rd_shadow_q <= rd_toggle;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rdata_q     <= rdata_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
        end
    end

    // Storage array, no reset so it maps onto distributed RAM.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = rdata_q;
    assign count = count_q;
    assign empty = is_empty;
    assign full  = is_full;
    assign ovf   = ovf_q;
    assign unf   = unf_q;

endmodule

// File: rtl/usb_pulpino_mailbox.sv
// Bidirectional USB <-> PULPino mailbox: two independent toggle FIFOs.
module usb_pulpino_mailbox
    import usb_pulpino_pkg::*;
#(
    parameter int unsigned pDATA_WIDTH = DefDataWidth,
    parameter int unsigned pDEPTH      = DefDepth,
    parameter int unsigned pCNT_W      = CNT_W(pDEPTH)
) (
    input  logic                   clk,
    input  logic                   reset_i,
    input  logic                   usb_wr_toggle,
    input  logic [pDATA_WIDTH-1:0] usb_wdata,
    input  logic                   usb_rd_toggle,
    output logic [pDATA_WIDTH-1:0] usb_rdata,
    input  logic                   pul_wr_toggle,
    input  logic [pDATA_WIDTH-1:0] pul_wdata,
    input  logic                   pul_rd_toggle,
    output logic [pDATA_WIDTH-1:0] pul_rdata,
    output logic [pCNT_W-1:0]      u2p_count,
    output logic [pCNT_W-1:0]      p2u_count,
    output logic                   u2p_empty,
    output logic                   u2p_full,
    output logic                   p2u_empty,
    output logic                   p2u_full,
    output logic                   u2p_ovf,
    output logic                   p2u_ovf,
    output logic                   u2p_unf,
    output logic                   p2u_unf,
    input  logic                   clr_err
);

    // USB writes, PULPino reads.
    toggle_fifo #(
        .DataWidth (pDATA_WIDTH),
        .Depth     (pDEPTH),
        .CntW      (pCNT_W)
    ) u_u2p (
        .clk       (clk),
        .reset_i   (reset_i),
        .wr_toggle (usb_wr_toggle),
        .wdata     (usb_wdata),
        .rd_toggle (pul_rd_toggle),
        .clr_err   (clr_err),
        .rdata     (pul_rdata),
        .count     (u2p_count),
        .empty     (u2p_empty),
        .full      (u2p_full),
        .ovf       (u2p_ovf),
        .unf       (u2p_unf)
    );

    // PULPino writes, USB reads.
    toggle_fifo #(
        .DataWidth (pDATA_WIDTH),
        .Depth     (pDEPTH),
        .CntW      (pCNT_W)
    ) u_p2u (
        .clk       (clk),
        .reset_i   (reset_i),
        .wr_toggle (pul_wr_toggle),
        .wdata     (pul_wdata),
        .rd_toggle (usb_rd_toggle),
        .clr_err   (clr_err),
        .rdata     (usb_rdata),
        .count     (p2u_count),
        .empty     (p2u_empty),
        .full      (p2u_full),
        .ovf       (p2u_ovf),
        .unf       (p2u_unf)
    );

endmodule

// File: doc/usb_pulpino_mailbox.md
# usb_pulpino_mailbox

Parametrised, bidirectional, FIFO-buffered mailbox between the USB register block and the PULPino GPIO port, replacing the single-word, unbuffered USB/PULPino channel. Each direction carries `pDATA_WIDTH`-bit words through a `pDEPTH`-entry FIFO. Push and pop are signalled by toggle ("flicker") inputs. Occupancy, full/empty and sticky error flags are exported so both firmware and host can poll them. The block sits in the `pulpino_clk` domain. All USB-side inputs arrive already registered in that domain by the register block.

## Interface
- `pDATA_WIDTH`, 8: word width, both directions.
- `pDEPTH`, 8: FIFO entries per direction. Must be a power of two, ≥ 2.
- `pCNT_W`, `$clog2(pDEPTH)+1`: occupancy counter width (derived; do not override).

- `clk`  in  1  the `pulpino_clk` domain. Single clock: one clock; reset is synchronous and active-high.
- `reset_i`  in  1  synchronous, active-high reset.
- `usb_wr_toggle`  in  1  any change pushes `usb_wdata` into the u2p FIFO.
- `usb_wdata`  in  W  USB→PULPino data word.
- `usb_rd_toggle`  in  1  any change pops the p2u FIFO.
- `usb_rdata`  out  W  head of the p2u FIFO; 0 when empty.
- `pul_wr_toggle`  in  1  any change pushes `pul_wdata` into the p2u FIFO.
- `pul_wdata`  in  W  PULPino→USB data word.
- `pul_rd_toggle`  in  1  any change pops the u2p FIFO.
- `pul_rdata`  out  W  head of the u2p FIFO; 0 when empty.
- `u2p_count`, `p2u_count`  out  pCNT_W  occupancy, range 0..pDEPTH.
- `u2p_empty`, `u2p_full`, `p2u_empty`, `p2u_full`  out  1  occupancy flags.
- `u2p_ovf`, `p2u_ovf`, `u2p_unf`, `p2u_unf`  out  1  sticky overflow/underflow flags.
- `clr_err`  in  1  one-cycle pulse; clears all four sticky flags.

## Operation
- **Toggle detection.** Each toggle input has a registered shadow copy, reset to 0.
  - An event occurs on every `clk` edge where input ≠ shadow. The shadow then takes the input value.
  - A toggle held stable produces no further events.
  - Toggles must be 0 at reset release. A toggle already at 1 during reset produces one event on the first cycle after release (required, not a bug).
- **Push** (FIFO not full): write the data word at `wr_ptr`, then `wr_ptr++` modulo pDEPTH.
- **Push while full:** the word is dropped and `*_ovf` is set. Pointers and count are unchanged.
- **Pop** (FIFO not empty): `rd_ptr++` modulo pDEPTH.
- **Pop while empty:** `*_unf` is set. Nothing else changes.
- **Simultaneous push and pop on one FIFO:**
  - Non-empty, not full: both proceed; count unchanged.
  - Full: both proceed; count stays pDEPTH; no overflow.
  - Empty: the push proceeds and the pop is an underflow; count becomes 1.
- **Count:** +1 on push-only, −1 on pop-only. `empty = (count==0)`, `full = (count==pDEPTH)`.
- **Read data:** `*_rdata` is registered and equals `mem[rd_ptr]` after each update, or 0 when the post-update count is 0. The head word is never consumed by reading, only by a pop.
- **Error flags:** `clr_err` has priority over a same-cycle error set, so a flag being set in that cycle is cleared.
- **The two directions are fully independent.** Events on both sides in the same cycle are all honoured.

## Timing
- **Reset values:** pointers, counts and shadows 0; `*_rdata` 0; `*_empty` 1; `*_full` 0; all error flags 0.
- **Reset mid-operation:** all stored words are discarded and every output returns to its reset value on the next edge. Memory contents need no reset.
- **Latency:** a toggle change visible before edge N is acted on at edge N.
  - Count, flags and `*_rdata` reflect the change after edge N, i.e. one cycle of latency.
  - A word pushed into an empty FIFO appears on `*_rdata` one cycle after the push edge.
- **Throughput:** one push and one pop per FIFO per cycle. A writer may flip its toggle every cycle.
- **Polling rule:** a writer must poll `*_full` before toggling. No acknowledge handshake exists beyond the count/flag outputs.

## Structure
- Package `usb_pulpino_pkg`: default `pDATA_WIDTH` and `pDEPTH`, a `CNT_W(depth)` helper, and the GPIO bit-position constants for the status/flag fields.
- Sub-module `toggle_fifo`: one direction (shadows, pointers, count, memory, rdata register, sticky flags). It is instantiated twice, as u2p and p2u.
- The top only wires the ports and fans out `clr_err`.
- Memory is inferred as distributed RAM (pDEPTH × W).

## Test plan
1. Reset, then 5 `usb_wr_toggle` flips with data 0x11..0x15, then 5 `pul_rd_toggle` flips. Required: `pul_rdata` shows 0x11..0x15 in order, `u2p_count` steps 1..5 then back to 0, `u2p_empty`=1 at the end, no error flags set.
2. pDEPTH=8: 9 pushes into p2u (0xA0..0xA8). Required: `p2u_full`=1 after the 8th push, `p2u_ovf`=1 after the 9th, and 8 pops return 0xA0..0xA7.
3. Pop an empty FIFO. Required: `u2p_unf`=1 with count still 0. Then pulse `clr_err` in the same cycle as a further underflow. Required: flag reads 0.
4. Full FIFO, push 0x55 and pop in the same cycle. Required: count stays 8, no overflow, and after draining the final word is 0x55. Empty FIFO, push 0x66 and pop in the same cycle. Required: count 1, `rdata`=0x66, `unf`=1.
5. 20 push/pop pairs through pDEPTH=8 to force pointer wrap. Required: data integrity across the wrap. Assert `reset_i` for one cycle with count 3. Required: count 0, `rdata` 0, `empty` 1 on the next cycle.
